apb_mem_slave: RTL
==================

// Module: apb_mem_slave
// PURPOSE
//  Parametrised APB4 completer backed by a byte-writable flop memory of DEPTH words.
//  Adds programmable wait states, pstrb byte-lane writes, decode/protocol error
//  signalling on pslverr, and a saturating error counter.
//  Sits behind the APB master/interconnect as the bench and system scratch-memory target.
// PARAMETERS
//  ADDR_W       16   paddr width (bits)
//  DATA_W       32   data width; must be 8, 16 or 32
//  DEPTH        64   number of DATA_W words; DEPTH*(DATA_W/8) <= 2**ADDR_W
//  WAIT_STATES  0    pready-low cycles in ACCESS phase before completion (0..15)
// PORTS
//  clk      in   1         clock, rising edge
//  rstn     in   1         reset, synchronous, active-low
//  paddr    in   ADDR_W    byte address
//  pprot    in   3         APB4 protection attributes
//  psel     in   1         completer select
//  penable  in   1         ACCESS phase indicator
//  pwrite   in   1         1=write, 0=read
//  pwdata   in   DATA_W    write data
//  pstrb    in   DATA_W/8  write byte-lane strobes
//  pready   out  1         transfer completes this cycle
//  prdata   out  DATA_W    read data, valid when pready & !pwrite & !pslverr
//  pslverr  out  1         error response, valid only with pready
//  err_cnt  out  8         saturating count of completed error transfers
// BEHAVIOUR
//  Reset: state=IDLE, wait counter=0, every memory word=0, err_cnt=0;
//   pready=0, pslverr=0, prdata=0.
//  FSM (two states):
//   IDLE:   psel & !penable (SETUP) -> ACCESS; load cnt=WAIT_STATES.
//           psel & penable without a prior SETUP is ignored; pready stays 0.
//   ACCESS: !psel -> IDLE (abort); no write, no err_cnt update.
//           psel & cnt!=0 -> cnt-1, pready=0.
//           psel & cnt==0 -> pready=1 this cycle -> IDLE.
//  pready = (state==ACCESS) & psel & penable & (cnt==0). Derived combinationally from registers.
//  Latency: completion lands WAIT_STATES+1 cycles after the SETUP edge.
//   WAIT_STATES=0 gives standard two-cycle APB.
//  Back-to-back: a SETUP in the cycle after completion is accepted. No idle cycle is needed.
//  Decode: idx = paddr >> log2(DATA_W/8). err asserts for any of:
//   - misaligned (low byte-offset bits !=0)
//   - idx >= DEPTH
//   - read with pstrb != 0
//  Write commits at the completing edge, only if !err; only lanes with pstrb[i]=1 update.
//   pstrb==0 write completes OKAY with no change.
//  Read: prdata = mem[idx] when pready & !pwrite & !err, else 0.
//   Address/control are sampled in ACCESS; the master holds them stable.
//  pslverr = pready & err; 0 in every other cycle.
//  err_cnt: +1 on each completing error transfer; saturates at 255, never wraps.
//  Reset mid-transfer: next cycle is IDLE with outputs at reset values. The pending write is dropped.
// CONFIGURATION
//  APB_MEM_PROT_CHK_EN defined:
//   Upper half of the array (idx >= DEPTH/2) is secure.
//   Any access with pprot[1]=1 (non-secure) to it -> err: no write, prdata=0, pslverr=1.
//  APB_MEM_PROT_CHK_EN undefined: pprot is ignored entirely.
// STRUCTURE
//  Package apb_mem_pkg:
//   - state_t enum {IDLE, ACCESS}
//   - localparam function clog2-based IDX_W / OFS_W helpers
//   - ERR_CNT_MAX=8'hFF
//  Sub-module apb_mem_array: DEPTH x DATA_W flop array with
//   - per-byte write enables
//   - combinational read port
//   - synchronous clear
//  Top holds the FSM, wait counter, decode, error logic and err_cnt.
// TESTING
//  1 WAIT_STATES=0:
//    write 0x10=0xDEADBEEF with pstrb=F, then read 0x10
//    -> pready on 2nd cycle of each transfer; prdata=0xDEADBEEF; pslverr=0
//  2 WAIT_STATES=3:
//    read 0x0 after reset
//    -> pready low 3 ACCESS cycles, high on 4th; prdata=0
//  3 Write 0x20=0x11223344 with pstrb=F, then write 0x20=0xAABBCCDD with pstrb=4'b0101, then read 0x20
//    -> 0x11BB33DD
//  4 Error transfers:
//    - read 0x102 (misaligned)
//    - write idx=DEPTH (0x100)
//    - read with pstrb=1
//    -> pslverr=1 with pready on each; memory unchanged; err_cnt=3
//  5 Drop psel mid-ACCESS (WAIT_STATES=2) on a write to 0x8
//    -> FSM returns to IDLE; mem[2] unchanged; next transfer completes normally
//  6 Saturation and reset:
//    - 260 error transfers -> err_cnt=255
//    - assert rstn=0 mid-ACCESS -> err_cnt=0, pready=0, memory cleared
//    - with APB_MEM_PROT_CHK_EN: write to idx=DEPTH-1 with pprot=3'b010 -> pslverr=1

Source files
------------

// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared types and sizing helpers for the APB scratch-memory completer.
//   state_t       : completer FSM states (IDLE, ACCESS)
//   idx_w()       : word-index width for a DEPTH-word array (at least 1 bit)
//   ofs_w()       : byte-offset width inside one DATA_W word
//   ERR_CNT_MAX   : saturation value of the error counter
package apb_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int ofs_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array: DEPTH x DATA_W flop array with per-byte write enables,
// a combinational read port and a synchronous clear on rstn.
// Ports:
//   clk      in  clock, rising edge
//   rstn     in  synchronous active-low clear of every word
//   addr     in  word index shared by the read and write ports
//   byte_we  in  per-byte write enables (bit b writes wdata[8b+7:8b])
//   wdata    in  write data
//   rdata    out combinational read of mem[addr]
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W/8-1:0]   byte_we,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int BYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear wins over a same-cycle write, so a write caught by reset is dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else begin
      for (int b = 0; b < BYTES; b++) begin
        if (byte_we[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB4 completer backed by a byte-writable flop memory.
// Programmable wait states, pstrb byte-lane writes, error response on
// pslverr for misaligned / out-of-range / read-with-strobe accesses, and a
// saturating count of completed error transfers.
// Optional build macro APB_MEM_PROT_CHK_EN: the upper half of the array is
// secure and non-secure accesses (pprot[1]=1) to it are errored. Without the
// macro pprot is ignored.
// Ports:
//   clk, rstn            clock (rising edge), synchronous active-low reset
//   paddr, pprot         byte address, APB4 protection attributes
//   psel, penable        select, ACCESS phase indicator
//   pwrite, pwdata, pstrb direction, write data, write byte strobes
//   pready               transfer completes this cycle
//   prdata               read data (0 unless an OKAY read completes)
//   pslverr              error response, only with pready
//   err_cnt              saturating count of completed error transfers
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_W-1:0]     paddr,
  input  logic [2:0]            pprot,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W/8-1:0]   pstrb,
  output logic                  pready,
  output logic [DATA_W-1:0]     prdata,
  output logic                  pslverr,
  output logic [7:0]            err_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFS_W = ofs_w(DATA_W);
  localparam int IDX_W = idx_w(DEPTH);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  err_cnt_q;

  logic [ADDR_W-1:0] idx_full;
  logic [IDX_W-1:0]  arr_idx;
  logic              misaligned, in_range, rd_strb_err, prot_err, err;
  logic              wr_commit;
  logic [BYTES-1:0]  byte_we;
  logic [DATA_W-1:0] rd_word;

  // Address decode
  assign idx_full    = paddr >> OFS_W;
  assign misaligned  = |(paddr & ADDR_W'(BYTES - 1));
  assign in_range    = {1'b0, idx_full} < (ADDR_W + 1)'(DEPTH);
  assign rd_strb_err = !pwrite && (|pstrb);

`ifdef APB_MEM_PROT_CHK_EN
  logic unused_pprot;
  assign unused_pprot = ^{pprot[2], pprot[0]};
  assign prot_err     = pprot[1] && ({1'b0, idx_full} >= (ADDR_W + 1)'(DEPTH / 2));
`else
  logic unused_pprot;
  assign unused_pprot = ^pprot;
  assign prot_err     = 1'b0;
`endif

  assign err = misaligned || !in_range || rd_strb_err || prot_err;

  // Out-of-range indices are parked on word 0 so the array is never indexed
  // past its end; such accesses are errored and never write or return data.
  assign arr_idx = in_range ? idx_full[IDX_W-1:0] : '0;

  // FSM state register and wait counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // ACCESS-phase signals without a preceding SETUP are ignored here.
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (penable) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pready = (state_q == ACCESS) && psel && penable && (cnt_q == '0);

  // Completion: write commit, read return, error response
  assign wr_commit = pready && pwrite && !err;
  assign byte_we   = wr_commit ? pstrb : '0;
  assign prdata    = (pready && !pwrite && !err) ? rd_word : '0;
  assign pslverr   = pready && err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_cnt_q <= '0;
    end else if (pslverr && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rstn    (rstn),
    .addr    (arr_idx),
    .byte_we (byte_we),
    .wdata   (pwdata),
    .rdata   (rd_word)
  );

endmodule
